regfile_write_arbiter: RTL and testbench

//  Owns the single register-file write port. Pipeline writeback (RegWrite/WriteAddress/RegInData from
//  the writeback stage) always wins; results from the long-latency unit (mul/div) are buffered in a

---
 rtl/regfile_write_arbiter.sv | 133 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter. The writeback stage always owns the
// port. Long-latency (mul/div) results wait in a small FIFO and drain into
// idle port cycles. Younger pipeline writes kill older buffered results to
// the same register (WAW). A bubble is requested when the FIFO is full or
// its head has waited too long.
module regfile_write_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_regwrite_i,
   input  logic [4:0]  wb_addr_i,
   input  logic [31:0] wb_data_i,
   input  logic        lu_valid_i,
   input  logic [4:0]  lu_addr_i,
   input  logic [31:0] lu_data_i,
   output logic        lu_ready_o,
   output logic        rf_we_o,
   output logic [4:0]  rf_addr_o,
   output logic [31:0] rf_data_o,
   input  logic [4:0]  hz_addr_i,
   output logic        hz_pending_o,
   output logic        stall_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [DEPTH-1:0] r_live;
   logic [4:0]       r_addr [DEPTH];
   logic [31:0]      r_data [DEPTH];
   logic [PW-1:0]    r_rd_ptr;
   logic [PW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic [SW-1:0]    r_starve;

   logic w_pipe_act;
   logic w_empty;
   logic w_full;
   logic w_lu_nz;
   logic w_pop;
   logic w_bypass;
   logic w_push;
   logic w_push_live;
   logic w_hz;

   // A write to x0 is architecturally a no-op, so it never claims the port.
   assign w_pipe_act  = wb_regwrite_i & (wb_addr_i != 5'd0);
   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == CW'(DEPTH));
   assign w_lu_nz     = (lu_addr_i != 5'd0);
   assign w_pop       = ~reset & ~w_pipe_act & ~w_empty;
   assign w_bypass    = ~reset & ~w_pipe_act & w_empty & lu_valid_i & w_lu_nz;
   assign lu_ready_o  = ~w_full | w_pop;
   assign w_push      = lu_valid_i & lu_ready_o & w_lu_nz & ~w_bypass;
   // An lu result arriving alongside a pipeline write to the same register
   // is already stale: the pipeline instruction is younger.
   assign w_push_live = ~(w_pipe_act & (wb_addr_i == lu_addr_i));
   assign stall_o     = w_full | (r_starve == SW'(STARVE_LIMIT));

   // Write-port mux: pipeline, then FIFO head, then lu bypass; silent in reset.
   always_comb begin
      rf_we_o   = 1'b0;
      rf_addr_o = 5'd0;
      rf_data_o = 32'd0;
      if (!reset) begin
         if (w_pipe_act) begin
            rf_we_o   = 1'b1;
            rf_addr_o = wb_addr_i;
            rf_data_o = wb_data_i;
         end else if (!w_empty) begin
            rf_we_o   = r_live[r_rd_ptr];
            rf_addr_o = r_addr[r_rd_ptr];
            rf_data_o = r_data[r_rd_ptr];
         end else if (w_bypass) begin
            rf_we_o   = 1'b1;
            rf_addr_o = lu_addr_i;
            rf_data_o = lu_data_i;
         end
      end
   end

   // Hazard lookup over live entries; live is cleared on pop so it implies occupied.
   always_comb begin
      w_hz = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_live[i] && (r_addr[i] == hz_addr_i)) w_hz = 1'b1;
      end
      hz_pending_o = w_hz & (hz_addr_i != 5'd0);
   end

   // Control state: pointers, occupancy, live bits with WAW kill, starve timer.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_live   <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_starve <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_pipe_act && (r_addr[i] == wb_addr_i)) r_live[i] <= 1'b0;
         end
         if (w_pop) begin
            r_live[r_rd_ptr] <= 1'b0;
            r_rd_ptr         <= r_rd_ptr + PW'(1);
         end
         // Push last: when full with pop+push the same slot is reused.
         if (w_push) begin
            r_live[r_wr_ptr] <= w_push_live;
            r_wr_ptr         <= r_wr_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_empty || w_pop)                    r_starve <= '0;
         else if (r_starve != SW'(STARVE_LIMIT))  r_starve <= r_starve + SW'(1);
      end
   end

   // Payload storage; validity is tracked by r_live, so no reset needed.
   always_ff @(posedge clk) begin
      if (!reset && w_push) begin
         r_addr[r_wr_ptr] <= lu_addr_i;
         r_data[r_wr_ptr] <= lu_data_i;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: stimulus pushes every expected register-file write into
// a queue; a monitor on the falling edge pops and compares each rf write.
module tb_regfile_write_arbiter;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_regwrite_i;
   logic [4:0]  wb_addr_i;
   logic [31:0] wb_data_i;
   logic        lu_valid_i;
   logic [4:0]  lu_addr_i;
   logic [31:0] lu_data_i;
   logic        lu_ready_o;
   logic        rf_we_o;
   logic [4:0]  rf_addr_o;
   logic [31:0] rf_data_o;
   logic [4:0]  hz_addr_i;
   logic        hz_pending_o;
   logic        stall_o;

   int    checks = 0;
   int    failures = 0;
   wr_t   exp_q[$];
   logic [31:0] rf_model [32];

   regfile_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
      .clk(clk), .reset(reset),
      .wb_regwrite_i(wb_regwrite_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
      .lu_valid_i(lu_valid_i), .lu_addr_i(lu_addr_i), .lu_data_i(lu_data_i),
      .lu_ready_o(lu_ready_o),
      .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o),
      .hz_addr_i(hz_addr_i), .hz_pending_o(hz_pending_o), .stall_o(stall_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
      wb_regwrite_i = we; wb_addr_i = wa; wb_data_i = wd;
      lu_valid_i = lv; lu_addr_i = la; lu_data_i = ld;
      #1;
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      wr_t w;
      w.a = a; w.d = d;
      exp_q.push_back(w);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Monitor: every rf write must match the oldest expected write.
   always @(negedge clk) begin
      wr_t e;
      if (rf_we_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write_addr", {27'd0, rf_addr_o}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {27'd0, rf_addr_o}, {27'd0, e.a});
            chk("wr_data", rf_data_o, e.d);
         end
         rf_model[rf_addr_o] = rf_data_o;
      end
   end

   initial begin
      for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
      reset = 1'b1; hz_addr_i = 5'd1;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick(); tick();
      reset = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk("rst_lu_ready", {31'd0, lu_ready_o}, 32'd1);
      chk("rst_stall", {31'd0, stall_o}, 32'd0);
      chk("rst_rf_we", {31'd0, rf_we_o}, 32'd0);
      chk("rst_hz", {31'd0, hz_pending_o}, 32'd0);

      // 1: idle pipeline, lu x5 bypasses straight to the port.
      expect_wr(5'd5, 32'h1234);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
      chk("t1_rf_we", {31'd0, rf_we_o}, 32'd1);
      tick();
      hz_addr_i = 5'd5;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk("t1_no_enqueue_we", {31'd0, rf_we_o}, 32'd0);
      chk("t1_hz", {31'd0, hz_pending_o}, 32'd0);
      tick();

      // 2: pipeline busy 6 cycles, lu pushes x1..x4 and fills the FIFO.
      hz_addr_i = 5'd2;
      for (int i = 0; i < 6; i++) begin
         expect_wr(5'(10 + i), 32'h100 + i);
         if (i < 4) drive(1'b1, 5'(10 + i), 32'h100 + i, 1'b1, 5'(i + 1), 32'h201 + i);
         else       drive(1'b1, 5'(10 + i), 32'h100 + i, 1'b0, 5'd0, 32'd0);
         if (i < 4) chk("t2_ready_filling", {31'd0, lu_ready_o}, 32'd1);
         else begin
            chk("t2_ready_full", {31'd0, lu_ready_o}, 32'd0);
            chk("t2_stall_full", {31'd0, stall_o}, 32'd1);
            chk("t2_hz_x2", {31'd0, hz_pending_o}, 32'd1);
         end
         tick();
      end
      for (int i = 0; i < 4; i++) expect_wr(5'(i + 1), 32'h201 + i);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
         chk("t2_drain_we", {31'd0, rf_we_o}, 32'd1);
         tick();
         chk("t2_stall_after_pop", {31'd0, stall_o}, 32'd0);
      end
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk("t2_empty_we", {31'd0, rf_we_o}, 32'd0);
      tick();

      // 3: buffered x7 killed by younger pipeline write to x7.
      hz_addr_i = 5'd7;
      expect_wr(5'd9, 32'h1);
      drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd7, 32'hAAAA);
      tick();
      chk("t3_hz_before", {31'd0, hz_pending_o}, 32'd1);
      expect_wr(5'd7, 32'hBBBB);
      drive(1'b1, 5'd7, 32'hBBBB, 1'b0, 5'd0, 32'd0);
      tick();
      chk("t3_hz_after_kill", {31'd0, hz_pending_o}, 32'd0);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk("t3_killed_pop_we", {31'd0, rf_we_o}, 32'd0);
      tick();

      // 4: head starves behind continuous pipeline writes.
      expect_wr(5'd20, 32'h500);
      drive(1'b1, 5'd20, 32'h500, 1'b1, 5'd8, 32'h8888);
      tick();
      for (int j = 0; j < 8; j++) begin
         expect_wr(5'd20, 32'h510 + j);
         drive(1'b1, 5'd20, 32'h510 + j, 1'b0, 5'd0, 32'd0);
         chk("t4_no_stall_yet", {31'd0, stall_o}, 32'd0);
         tick();
      end
      chk("t4_stall_at_limit", {31'd0, stall_o}, 32'd1);
      expect_wr(5'd8, 32'h8888);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      chk("t4_stall_cleared", {31'd0, stall_o}, 32'd0);

      // 5: x0 traffic never writes and never enqueues.
      hz_addr_i = 5'd0;
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5555);
      chk("t5_lu_x0_we", {31'd0, rf_we_o}, 32'd0);
      chk("t5_lu_x0_ready", {31'd0, lu_ready_o}, 32'd1);
      tick();
      drive(1'b1, 5'd0, 32'h6666, 1'b0, 5'd0, 32'd0);
      chk("t5_wb_x0_we", {31'd0, rf_we_o}, 32'd0);
      chk("t5_hz_x0", {31'd0, hz_pending_o}, 32'd0);
      tick();
      expect_wr(5'd3, 32'h3333);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h3333);
      chk("t5_still_empty_bypass", {31'd0, rf_we_o}, 32'd1);
      tick();

      // 6: fill across pointer wrap, pop+push while full, then reset.
      for (int i = 0; i < 4; i++) begin
         expect_wr(5'(21 + i), 32'h400 + i);
         drive(1'b1, 5'(21 + i), 32'h400 + i, 1'b1, 5'(i + 1), 32'h301 + i);
         tick();
      end
      expect_wr(5'd1, 32'h301);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h305);
      chk("t6_ready_popfull", {31'd0, lu_ready_o}, 32'd1);
      tick();
      chk("t6_still_full_stall", {31'd0, stall_o}, 32'd1);
      expect_wr(5'd25, 32'h404);
      drive(1'b1, 5'd25, 32'h404, 1'b1, 5'd6, 32'h306);
      chk("t6_ready_blocked", {31'd0, lu_ready_o}, 32'd0);
      tick();
      expect_wr(5'd2, 32'h302);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h306);
      chk("t6_ready_popfull2", {31'd0, lu_ready_o}, 32'd1);
      tick();
      expect_wr(5'd3, 32'h303);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      hz_addr_i = 5'd5;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk("t6_hz_x5_buffered", {31'd0, hz_pending_o}, 32'd1);
      reset = 1'b1;
      #1;
      chk("t6_reset_cycle_we", {31'd0, rf_we_o}, 32'd0);
      tick();
      reset = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk("t6_post_rst_we", {31'd0, rf_we_o}, 32'd0);
      chk("t6_post_rst_ready", {31'd0, lu_ready_o}, 32'd1);
      chk("t6_post_rst_stall", {31'd0, stall_o}, 32'd0);
      chk("t6_post_rst_hz", {31'd0, hz_pending_o}, 32'd0);
      expect_wr(5'd9, 32'h9999);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9999);
      chk("t6_post_rst_bypass", {31'd0, rf_we_o}, 32'd1);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick(); tick();

      chk("all_writes_seen", exp_q.size(), 32'd0);
      chk("x7_final", rf_model[7], 32'hBBBB);
      chk("x8_final", rf_model[8], 32'h8888);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
